// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches through a READ/BUSYWAIT handshake, redirects on BRANCH/JUMP.
// Optional saturating taken-redirect counter enabled by defining IFU_TAKEN_COUNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic              IMEM_READ,
    output logic [ADDR_W-1:0] IMEM_ADDRESS,
    input  logic [31:0]       IMEM_READDATA,
    input  logic              IMEM_BUSYWAIT,
    output logic [31:0]       INSTRUCTION,
    output logic              INSTR_VALID,
    output logic [31:0]       PC,
    input  logic              BRANCH,
    input  logic              JUMP,
    input  logic              ZERO,
    input  logic              STALL,
    output logic [15:0]       TAKEN_COUNT
);

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  FETCH = 2'd1;
    localparam logic [1:0]  EXEC  = 2'd2;
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    logic [1:0]         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic               r_valid;
    logic               r_read;

    logic [31:0]        w_pc_plus4;
    logic signed [31:0] w_offset;
    logic               w_taken;
    logic [31:0]        w_next_pc;

    // Branch offset is a signed word count relative to the following instruction.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_offset   = {{22{r_instr[23]}}, r_instr[23:16], 2'b00};
    assign w_taken    = JUMP | (BRANCH & ZERO);
    assign w_next_pc  = w_taken ? (w_pc_plus4 + $unsigned(w_offset)) : w_pc_plus4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_pc    <= PC_INIT;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_read  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_read  <= 1'b1;
                end
                FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        r_instr <= IMEM_READDATA;
                        r_state <= EXEC;
                        r_read  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!STALL) begin
                        r_pc    <= w_next_pc;
                        r_state <= FETCH;
                        r_read  <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_read  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign IMEM_READ    = r_read;
    assign IMEM_ADDRESS = r_pc[ADDR_W-1:0];
    assign INSTRUCTION  = r_instr;
    assign INSTR_VALID  = r_valid;
    assign PC           = r_pc;

`ifdef IFU_TAKEN_COUNT_EN
    logic [15:0] r_taken_cnt;
    logic        w_exec_exit;

    assign w_exec_exit = (r_state == EXEC) && !STALL;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_taken_cnt <= '0;
        end else if (w_exec_exit && w_taken && (r_taken_cnt != 16'hFFFF)) begin
            r_taken_cnt <= r_taken_cnt + 16'd1;
        end
    end

    assign TAKEN_COUNT = r_taken_cnt;
`else
    assign TAKEN_COUNT = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed steps plus randomized instructions
// compared against a transaction-level model of the PC, fetched word and taken count.
module tb_instruction_fetch_unit;

    logic        CLK;
    logic        RESET;
    logic        IMEM_READ;
    logic [9:0]  IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;
    logic [31:0] PC;
    logic        BRANCH;
    logic        JUMP;
    logic        ZERO;
    logic        STALL;
    logic [15:0] TAKEN_COUNT;

    logic [31:0] imem [0:255];
    assign IMEM_READDATA = imem[IMEM_ADDRESS[9:2]];

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .INSTRUCTION(INSTRUCTION), .INSTR_VALID(INSTR_VALID), .PC(PC),
        .BRANCH(BRANCH), .JUMP(JUMP), .ZERO(ZERO), .STALL(STALL),
        .TAKEN_COUNT(TAKEN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] model_pc;
    logic [31:0] model_instr;
    int          model_taken;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_count();
`ifdef IFU_TAKEN_COUNT_EN
        return (model_taken > 65535) ? 32'hFFFF : 32'(model_taken);
`else
        return 32'h0;
`endif
    endfunction

    // Entered with the DUT in FETCH; leaves it in the FETCH of the following instruction.
    task automatic run_instr(input int busy, input int stall, input logic br, input logic jp, input logic zr);
        int   off;
        logic taken;
        for (int k = 0; k <= busy; k++) begin
            IMEM_BUSYWAIT = (k < busy);
            STALL  = 1'($urandom);
            BRANCH = 1'($urandom);
            JUMP   = 1'($urandom);
            ZERO   = 1'($urandom);
            check("fetch_read",  IMEM_READ, 1);
            check("fetch_addr",  IMEM_ADDRESS, model_pc[9:0]);
            check("fetch_valid", INSTR_VALID, 0);
            check("fetch_instr_hold", INSTRUCTION, model_instr);
            tick();
        end
        model_instr = imem[model_pc[9:2]];
        for (int k = 0; k <= stall; k++) begin
            STALL         = (k < stall);
            IMEM_BUSYWAIT = 1'($urandom);
            if (k < stall) begin
                BRANCH = 1'($urandom);
                JUMP   = 1'($urandom);
                ZERO   = 1'($urandom);
            end else begin
                BRANCH = br;
                JUMP   = jp;
                ZERO   = zr;
            end
            check("exec_valid", INSTR_VALID, 1);
            check("exec_read",  IMEM_READ, 0);
            check("exec_instr", INSTRUCTION, model_instr);
            check("exec_pc",    PC, model_pc);
            tick();
        end
        taken = jp || (br && zr);
        off   = $signed(model_instr[23:16]);
        model_pc = model_pc + 32'd4 + (taken ? 32'(off * 4) : 32'd0);
        if (taken) model_taken++;
        STALL = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        check("next_pc",      PC, model_pc);
        check("next_read",    IMEM_READ, 1);
        check("next_valid",   INSTR_VALID, 0);
        check("taken_count",  TAKEN_COUNT, exp_count());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        model_pc = 32'h0; model_instr = 32'h0; model_taken = 0;
        IMEM_BUSYWAIT = 1'b0; BRANCH = 1'b0; JUMP = 1'b0; ZERO = 1'b0; STALL = 1'b0;
        RESET = 1'b1;
        #2 RESET = 1'b0;
        tick(); tick();
        check("rst_read",  IMEM_READ, 0);
        check("rst_valid", INSTR_VALID, 0);
        check("rst_pc",    PC, 32'h0);
        check("rst_instr", INSTRUCTION, 32'h0);
        check("rst_count", TAKEN_COUNT, 32'h0);

        // Release reset; first edge leaves IDLE.
        imem[0] = 32'h0500_0007;
        #3 RESET = 1'b1;
        tick();
        run_instr(0, 0, 0, 0, 0);
        check("first_pc", PC, 32'h4);
        run_instr(0, 0, 1, 0, 0);
        run_instr(3, 0, 0, 0, 0);
        check("busy_pc", PC, 32'h0C);
        run_instr(0, 0, 0, 0, 1);

        imem[4] = 32'h01FE_0203;
        run_instr(0, 0, 0, 1, 0);
        check("jump_back", PC, 32'h0C);
        run_instr(0, 0, 0, 0, 0);
        imem[4] = 32'h0203_0000;
        run_instr(0, 0, 1, 0, 1);
        check("branch_taken", PC, 32'h20);
        run_instr(0, 0, 0, 0, 0);
        imem[9] = 32'h03FA_0000;
        run_instr(0, 2, 0, 1, 0);
        check("stall_jump", PC, 32'h10);
        imem[4] = 32'h0405_0000;
        run_instr(1, 1, 1, 0, 0);
        check("branch_not_taken", PC, 32'h14);
        imem[5] = 32'h0502_0000;
        run_instr(0, 0, 1, 1, 1);
        check("jump_and_branch", PC, 32'h20);

        for (int n = 0; n < 40; n++) begin
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Asynchronous reset during a busy fetch; late READDATA must be ignored.
        IMEM_BUSYWAIT = 1'b1;
        #3 RESET = 1'b0;
        #1;
        check("midrst_read",  IMEM_READ, 0);
        check("midrst_pc",    PC, 32'h0);
        check("midrst_valid", INSTR_VALID, 0);
        check("midrst_count", TAKEN_COUNT, 32'h0);
        IMEM_BUSYWAIT = 1'b0;
        tick();
        check("midrst_hold_instr", INSTRUCTION, 32'h0);
        check("midrst_hold_valid", INSTR_VALID, 0);
        model_pc = 32'h0; model_instr = 32'h0; model_taken = 0;
        imem[0]   = 32'h06FE_0000;
        imem[255] = 32'h0700_0000;
        #3 RESET = 1'b1;
        tick();
        check("restart_read", IMEM_READ, 1);
        check("restart_addr", IMEM_ADDRESS, 32'h0);
        run_instr(0, 0, 0, 1, 0);
        check("wrap_down", PC, 32'hFFFF_FFFC);
        run_instr(0, 0, 0, 0, 0);
        check("wrap_up", PC, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the control unit.
- Owns the program counter and fetches 32-bit instructions from instruction memory or cache through a READ/BUSYWAIT handshake.
- Presents the instruction, so OPCODE = INSTRUCTION[31:24], to decode and execute.
- Computes the next PC from the BRANCH and JUMP control signals and the ALU ZERO flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Bits [1:0] are forced to 0.
- ADDR_W, 10, width of the byte address driven to instruction memory (PC[ADDR_W-1:0]).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IMEM_READ  output  1  read request to instruction memory.
- IMEM_ADDRESS  output  ADDR_W  byte address of the fetch; equals PC[ADDR_W-1:0].
- IMEM_READDATA  input  32  instruction word, valid when IMEM_BUSYWAIT=0 while IMEM_READ=1.
- IMEM_BUSYWAIT  input  1  memory not ready; the fetch holds while high.
- INSTRUCTION  output  32  registered instruction: [31:24] opcode, [23:16] dest/imm/offset, [15:8] rt, [7:0] rs.
- INSTR_VALID  output  1  high while INSTRUCTION is being executed.
- PC  output  32  address of the current instruction.
- BRANCH  input  1  from the control unit.
- JUMP  input  1  from the control unit.
- ZERO  input  1  ALU result == 0.
- STALL  input  1  downstream (data memory) busy; holds the execute phase.
- TAKEN_COUNT  output  16  number of taken redirects (optional feature).

Behaviour:
- Reset (RESET=0, asynchronous, effective immediately):
  - state=IDLE, PC=RESET_PC & ~3, INSTRUCTION=0.
  - INSTR_VALID=0, IMEM_READ=0, TAKEN_COUNT=0.
  - Applies mid-fetch or mid-execute; any in-flight fetch is abandoned and a late READDATA is ignored.
- States, all outputs registered (Moore):
  - IDLE: the first rising edge after reset release goes to FETCH.
  - FETCH: IMEM_READ=1, IMEM_ADDRESS=PC[ADDR_W-1:0], INSTR_VALID=0.
    - At an edge with IMEM_BUSYWAIT=0: INSTRUCTION<=IMEM_READDATA, go to EXEC.
    - If BUSYWAIT stays high the state holds indefinitely; there is no timeout.
  - EXEC: IMEM_READ=0, INSTR_VALID=1. The control unit and ALU settle during this cycle.
    - At an edge with STALL=0: PC<=next_pc, go to FETCH.
    - STALL=1: hold EXEC; PC and INSTRUCTION unchanged.
- Next-PC rules:
  - pc_plus4 = PC + 4.
  - offset = sign-extend(INSTRUCTION[23:16]) << 2, in words, relative to pc_plus4.
  - taken = JUMP | (BRANCH & ZERO). JUMP with BRANCH both high counts as taken, with a single redirect.
  - next_pc = taken ? pc_plus4 + offset : pc_plus4.
  - All arithmetic is modulo 2^32; wrap-around is silent (0xFFFF_FFFC+4 = 0).
- Timing: minimum instruction time is 2 cycles (FETCH with BUSYWAIT=0, then EXEC). Each BUSYWAIT-high cycle and each STALL-high cycle adds one cycle.
- BRANCH, JUMP and ZERO are sampled only at the edge leaving EXEC and ignored in other states.
- IMEM_ADDRESS is stable for the whole FETCH phase.

Optional Feature:
- Macro: IFU_TAKEN_COUNT_EN.
- Defined: TAKEN_COUNT increments by 1 on each EXEC exit with taken=1 and saturates at 16'hFFFF.
- Undefined: TAKEN_COUNT is tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset release, BUSYWAIT=0, READDATA=0x0500_0007: IMEM_READ=1 with address 0 on cycle 1, INSTR_VALID=1 with INSTRUCTION=0x0500_0007 on cycle 2, PC=4 on cycle 3.
- BUSYWAIT held high 3 cycles during the fetch at PC=8: IMEM_READ and address 8 stable for 4 cycles; INSTRUCTION captured only after BUSYWAIT falls.
- PC=0x10, INSTRUCTION[23:16]=0xFE, JUMP=1 -> next PC=0x0C. With 0x03, BRANCH=1, ZERO=1 -> next PC=0x20. With BRANCH=1, ZERO=0 -> next PC=0x14.
- STALL=1 for 2 cycles in EXEC: INSTR_VALID stays 1, PC unchanged, next fetch begins one cycle after STALL drops.
- RESET driven low mid-FETCH with BUSYWAIT=1: IMEM_READ falls immediately, PC=RESET_PC, INSTR_VALID=0, and the fetch restarts from IDLE after release.
- With IFU_TAKEN_COUNT_EN, 3 taken branches plus 2 not-taken -> TAKEN_COUNT=3. Without the macro -> TAKEN_COUNT=0.
